imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader: the write-side counterpart of the CPU's read-only instruction memory port.
- Accepts a length-prefixed little-endian byte stream, e.g. from a UART receiver.
- Assembles the bytes into 32-bit words and writes them to the instruction BRAM's second port (write-only, one word per strobe).
- Holds the core in reset until the image is fully loaded.

Parameters:
- ADDR_W, 13, word-address width of the instruction BRAM. Matches the CPU-side word address pc[14:2].
- MAX_WORDS, 8192, largest accepted word count. Must be <= 2^ADDR_W.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  single-cycle pulse that begins a load. Honoured only in IDLE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  byte-stream ready. A byte transfers when in_valid && in_ready.
- mem_we  output  1  BRAM write strobe, one cycle per word.
- mem_addr  output  ADDR_W  BRAM word address.
- mem_wdata  output  32  BRAM write data.
- busy  output  1  load in progress (states LEN, DATA, WRITE, CKSUM).
- done  output  1  image loaded; sticky until reset.
- err  output  1  load rejected; sticky until next start or reset.
- cpu_run  output  1  1 releases the core's reset. Equals done.

Behaviour:
- Reset values: state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_run=0. Byte counter, word counter and shift register are all 0.
- Byte packing: the k-th accepted byte of a group (k=0..3) fills bits [8k+7:8k].
- IDLE:
  - in_ready=0.
  - start -> LEN, with byte count, word count and address cleared.
- LEN:
  - in_ready=1.
  - Collects 4 bytes into N, the 32-bit word count.
  - On acceptance of the 4th byte, transition next cycle:
    - N==0 -> DONE, with no writes.
    - N>MAX_WORDS -> ERR.
    - otherwise -> DATA.
- DATA:
  - in_ready=1.
  - On acceptance of the 4th byte of a word -> WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=word index, mem_wdata=assembled word, in_ready=0.
  - Index then increments. Counter width is ADDR_W+1, so there is no wrap at index MAX_WORDS.
  - If words written == N -> DONE (or CKSUM if enabled); else -> DATA.
- Latency:
  - mem_we rises in the cycle after the 4th byte of a word is accepted.
  - done/cpu_run rise in the cycle after the last WRITE.
- DONE:
  - done=1, cpu_run=1, in_ready=0.
  - start and in_valid are ignored. Leaves only via reset.
- ERR:
  - err=1, cpu_run=0, in_ready=0.
  - start -> LEN, clearing err in that cycle.
- Backpressure and gaps:
  - in_valid may drop for any number of cycles in LEN, DATA or CKSUM; state is held.
  - A byte presented during WRITE is not accepted. The source must hold it; it is never lost or duplicated.
- start while busy: ignored.
- Reset mid-operation: immediate return to reset values. Words already written remain in the BRAM; the core stays held.
- mem_addr and mem_wdata hold their last written value outside WRITE. They are valid only when mem_we=1.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- Defined:
  - After the last WRITE, enter CKSUM with in_ready=1 and accept one trailing byte.
  - That byte is compared with the 8-bit modulo-256 sum of all data bytes; the length bytes are excluded.
  - Match -> DONE. Mismatch -> ERR.
  - For N==0 the expected sum is 0x00 and CKSUM is still entered.
- Undefined: there is no CKSUM state and no trailing byte. The flow goes WRITE -> DONE directly.

Test Plan:
- Reset: assert rst=0 mid-clock with random inputs -> all outputs are 0 immediately (asynchronous) and stay 0 until start after release.
- Two-word load: start, then bytes 02 00 00 00 13 00 50 00 93 00 10 00 ->
  - mem_we pulses at addr 0 with data 0x00500013;
  - mem_we pulses at addr 1 with data 0x00100093;
  - done=cpu_run=1 one cycle after the second pulse;
  - exactly 2 strobes.
- Zero length: bytes 00 00 00 00 -> no mem_we; done=1 the cycle after the 4th byte. With the macro defined, checksum byte 00 is also required.
- Oversize: bytes 01 20 00 00 (N=8193) -> err=1, no mem_we, cpu_run=0. A following start -> err=0, busy=1, state LEN.
- Backpressure:
  - hold in_valid=1 continuously through a 3-word load -> in_ready=0 in each WRITE cycle and the byte held on in_data is taken the next cycle;
  - random in_valid gaps -> identical written words.
- Checksum and mid-load reset:
  - with IMEM_LOADER_CKSUM_EN, the two-word load followed by byte 0x7F (wrong; correct is 0x06) -> err=1, done=0;
  - rst=0 after 6 data bytes -> outputs reset and no further mem_we.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: write-side program loader for the instruction BRAM.
// Accepts a length-prefixed little-endian byte stream and packs it into 32-bit
// words. Each word goes out on the BRAM's write-only port as a one-cycle strobe.
// The core is held in reset (cpu_run=0) until the whole image has been loaded.
// Optional feature macro: IMEM_LOADER_CKSUM_EN. When defined, one trailing byte
// is accepted after the data. It must equal the modulo-256 sum of the data bytes.
module imem_loader #(
    parameter int ADDR_W    = 13,
    parameter int MAX_WORDS = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_run
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
`ifdef IMEM_LOADER_CKSUM_EN
        , ST_CKSUM = 3'd6
`endif
    } state_t;

    // State entered once the last data word is written, or for an empty image.
`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t TAIL_ST = ST_CKSUM;
`else
    localparam state_t TAIL_ST = ST_DONE;
`endif

    localparam logic [31:0] MAX_WORDS_C = 32'(MAX_WORDS);

    // Place byte number idx (0..2) of a word into the partial-word register.
    // Byte 3 never lands here: it completes the word directly from in_data.
    function automatic logic [23:0] pack_byte(input logic [23:0] cur,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
        logic [23:0] res;
        res = cur;
        case (idx)
            2'd0:    res[7:0]   = b;
            2'd1:    res[15:8]  = b;
            2'd2:    res[23:16] = b;
            default: res        = cur;
        endcase
        return res;
    endfunction

    // Running modulo-256 byte sum used by the optional trailing checksum.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t              state_r, state_next_s;
    logic [1:0]          byte_cnt_r, byte_cnt_next_s;
    logic [23:0]         shift_r, shift_next_s;
    logic [ADDR_W:0]     word_cnt_r, word_cnt_next_s;
    logic [ADDR_W:0]     word_inc_s;
    logic [31:0]         len_r, len_next_s;
    logic [31:0]         word_s;
    logic                accept_s;

    logic                in_ready_r, in_ready_next_s;
    logic                mem_we_r, we_next_s;
    logic [ADDR_W-1:0]   mem_addr_r, addr_next_s;
    logic [31:0]         mem_wdata_r, wdata_next_s;
    logic                busy_r, busy_next_s;
    logic                done_r, done_next_s;
    logic                err_r, err_next_s;
    logic                cpu_run_r;

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]          sum_r, sum_next_s;
`endif

    assign accept_s   = in_valid & in_ready_r;
    assign word_s     = {in_data, shift_r};
    assign word_inc_s = word_cnt_r + {{ADDR_W{1'b0}}, 1'b1};

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign cpu_run   = cpu_run_r;

    // Next-state and datapath update for the load sequencer.
    always_comb begin
        state_next_s    = state_r;
        byte_cnt_next_s = byte_cnt_r;
        shift_next_s    = shift_r;
        word_cnt_next_s = word_cnt_r;
        len_next_s      = len_r;
        we_next_s       = 1'b0;
        addr_next_s     = mem_addr_r;
        wdata_next_s    = mem_wdata_r;
`ifdef IMEM_LOADER_CKSUM_EN
        sum_next_s      = sum_r;
`endif
        case (state_r)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_next_s    = ST_LEN;
                    byte_cnt_next_s = 2'd0;
                    shift_next_s    = 24'd0;
                    word_cnt_next_s = {(ADDR_W+1){1'b0}};
                    len_next_s      = 32'd0;
`ifdef IMEM_LOADER_CKSUM_EN
                    sum_next_s      = 8'd0;
`endif
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LEN: begin
                if (accept_s) begin
                    if (byte_cnt_r == 2'd3) begin
                        len_next_s      = word_s;
                        byte_cnt_next_s = 2'd0;
                        shift_next_s    = 24'd0;
                        if (word_s == 32'd0) begin
                            state_next_s = TAIL_ST;
                        end else if (word_s > MAX_WORDS_C) begin
                            state_next_s = ST_ERR;
                        end else begin
                            state_next_s = ST_DATA;
                        end
                    end else begin
                        shift_next_s    = pack_byte(shift_r, byte_cnt_r, in_data);
                        byte_cnt_next_s = byte_cnt_r + 2'd1;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
`ifdef IMEM_LOADER_CKSUM_EN
                    sum_next_s = sum8(sum_r, in_data);
`endif
                    if (byte_cnt_r == 2'd3) begin
                        we_next_s       = 1'b1;
                        addr_next_s     = word_cnt_r[ADDR_W-1:0];
                        wdata_next_s    = word_s;
                        byte_cnt_next_s = 2'd0;
                        shift_next_s    = 24'd0;
                        state_next_s    = ST_WRITE;
                    end else begin
                        shift_next_s    = pack_byte(shift_r, byte_cnt_r, in_data);
                        byte_cnt_next_s = byte_cnt_r + 2'd1;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_WRITE: begin
                // The counter is one bit wider than the address, so an index
                // equal to MAX_WORDS still compares correctly against N.
                word_cnt_next_s = word_inc_s;
                if (32'(word_inc_s) == len_r) begin
                    state_next_s = TAIL_ST;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (accept_s) begin
                    if (in_data == sum_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
`endif
            ST_DONE: begin
                state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output flags decoded from the upcoming state, so they can be registered.
    always_comb begin
        in_ready_next_s = 1'b0;
        busy_next_s     = 1'b0;
        done_next_s     = 1'b0;
        err_next_s      = 1'b0;
        case (state_next_s)
            ST_LEN, ST_DATA: begin
                in_ready_next_s = 1'b1;
                busy_next_s     = 1'b1;
            end
            ST_WRITE: begin
                busy_next_s = 1'b1;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                in_ready_next_s = 1'b1;
                busy_next_s     = 1'b1;
            end
`endif
            ST_DONE: begin
                done_next_s = 1'b1;
            end
            ST_ERR: begin
                err_next_s = 1'b1;
            end
            default: begin
                in_ready_next_s = 1'b0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Byte/word counters, partial word, length and checksum accumulators.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_r <= 2'd0;
            shift_r    <= 24'd0;
            word_cnt_r <= {(ADDR_W+1){1'b0}};
            len_r      <= 32'd0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_r      <= 8'd0;
`endif
        end else begin
            byte_cnt_r <= byte_cnt_next_s;
            shift_r    <= shift_next_s;
            word_cnt_r <= word_cnt_next_s;
            len_r      <= len_next_s;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_r      <= sum_next_s;
`endif
        end
    end

    // Registered outputs. Address and data hold their last value between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            cpu_run_r   <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_next_s;
            mem_we_r    <= we_next_s;
            mem_addr_r  <= addr_next_s;
            mem_wdata_r <= wdata_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
            err_r       <= err_next_s;
            cpu_run_r   <= done_next_s;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. A queue-based reference model builds each byte
// stream from a list of words. It then predicts the write sequence and the
// final done/err outcome. All writes seen on the BRAM port are compared with it.
module tb_imem_loader;

    localparam int ADDR_W    = 13;
    localparam int MAX_WORDS = 8192;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_run;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W-1:0] got_a[$];
    logic [31:0]       got_d[$];
    logic [7:0]        stream_q[$];
    logic [31:0]       exp_w[$];
    int                exp_nw;
    bit                exp_ok;

    logic [51:0] outs_s;
    assign outs_s = {in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_run};

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_run  (cpu_run)
    );

    always #5 clk = ~clk;

    // Record every BRAM write strobe.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_we === 1'b1) begin
            got_a.push_back(mem_addr);
            got_d.push_back(mem_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_words(input int n);
        exp_w.delete();
        for (int i = 0; i < n; i++) exp_w.push_back($urandom);
    endtask

    // Reference model: byte stream for an image of n words taken from exp_w.
    task automatic build_stream(input logic [31:0] n);
        int sum;
        logic [7:0] b;
        sum = 0;
        stream_q.delete();
        for (int k = 0; k < 4; k++) stream_q.push_back(8'((n >> (8 * k)) & 32'hFF));
        if (n > 32'(MAX_WORDS)) begin
            exp_nw = 0;
            exp_ok = 1'b0;
        end else begin
            exp_nw = int'(n);
            exp_ok = 1'b1;
            for (int i = 0; i < exp_nw; i++) begin
                for (int k = 0; k < 4; k++) begin
                    b = 8'((exp_w[i] >> (8 * k)) & 32'hFF);
                    stream_q.push_back(b);
                    sum = sum + int'(b);
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            stream_q.push_back(8'(sum % 256));
`endif
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check_val("reset_async_outs", 64'(outs_s), 64'd0);
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        got_a.delete();
        got_d.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Feed stream_q with random gaps. Check each write strobe the cycle after its 4th byte.
    task automatic send_bytes(input int gap_pct);
        int idx;
        int budget;
        int nd;
        bit took;
        idx = 0;
        budget = 0;
        while (idx < stream_q.size() && budget < 3000) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = stream_q[idx];
            end
            if (mem_we === 1'b1) check_val("ready_low_in_write", 64'(in_ready), 64'd0);
            took = (in_valid === 1'b1) && (in_ready === 1'b1);
            @(posedge clk);
            #1;
            budget++;
            if (took) begin
                idx++;
                nd = idx - 4;
                if (nd > 0 && (nd % 4) == 0 && (nd / 4) <= exp_nw) begin
                    check_val("we_after_4th_byte", 64'(mem_we), 64'd1);
                    check_val("wr_addr", 64'(mem_addr), 64'(nd / 4 - 1));
                    check_val("wr_data", 64'(mem_wdata), 64'(exp_w[nd / 4 - 1]));
                end
            end
        end
        in_valid = 1'b0;
        if (idx < stream_q.size()) check_val("stream_timeout", 64'(idx), 64'(stream_q.size()));
    endtask

    // Final outcome and full write list against the model.
    task automatic finish_load();
`ifndef IMEM_LOADER_CKSUM_EN
        if (exp_nw > 0) begin
            check_val("done_low_in_last_write", 64'(done), 64'd0);
            @(posedge clk);
            #1;
        end
`endif
        if (exp_ok) begin
            check_val("done", 64'(done), 64'd1);
            check_val("cpu_run", 64'(cpu_run), 64'd1);
            check_val("busy_after_done", 64'(busy), 64'd0);
            check_val("err_after_done", 64'(err), 64'd0);
        end else begin
            check_val("err", 64'(err), 64'd1);
            check_val("done_after_err", 64'(done), 64'd0);
            check_val("cpu_run_after_err", 64'(cpu_run), 64'd0);
            check_val("busy_after_err", 64'(busy), 64'd0);
        end
        check_val("ready_when_finished", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("n_writes", 64'(got_a.size()), 64'(exp_nw));
        for (int i = 0; i < got_a.size() && i < exp_nw; i++) begin
            check_val("log_addr", 64'(got_a[i]), 64'(i));
            check_val("log_data", 64'(got_d[i]), 64'(exp_w[i]));
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        @(posedge clk);
        #1;

        // Asynchronous reset with random inputs, then quiet until start.
        start    = 1'($urandom);
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
            check_val("idle_outs", 64'(outs_s), 64'd0);
        end
        in_valid = 1'b0;

        // Two-word reference image.
        exp_w.delete();
        exp_w.push_back(32'h00500013);
        exp_w.push_back(32'h00100093);
        build_stream(32'd2);
        do_start();
        check_val("busy_in_len", 64'(busy), 64'd1);
        check_val("ready_in_len", 64'(in_ready), 64'd1);
        send_bytes(0);
        finish_load();
        // DONE ignores start and in_valid.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("done_sticky", 64'(done), 64'd1);
        check_val("done_busy_ignored", 64'(busy), 64'd0);
        check_val("done_ready_ignored", 64'(in_ready), 64'd0);
        check_val("done_no_more_writes", 64'(got_a.size()), 64'd2);

        // Zero-length image.
        do_reset();
        build_stream(32'd0);
        do_start();
        send_bytes(0);
        finish_load();

        // Oversize image (8193 words) is rejected; restart from ERR.
        do_reset();
        build_stream(32'd8193);
        do_start();
        send_bytes(0);
        finish_load();
        do_start();
        check_val("restart_err_cleared", 64'(err), 64'd0);
        check_val("restart_busy", 64'(busy), 64'd1);
        check_val("restart_ready", 64'(in_ready), 64'd1);

        // Three-word image with in_valid held high the whole time.
        fill_words(3);
        build_stream(32'd3);
        send_bytes(0);
        finish_load();

        // Same words again with random in_valid gaps.
        do_reset();
        build_stream(32'd3);
        do_start();
        send_bytes(40);
        finish_load();

        // Random images and random gap densities.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            fill_words($urandom_range(1, 6));
            build_stream(32'(exp_w.size()));
            do_start();
            send_bytes($urandom_range(0, 60));
            finish_load();
        end

`ifdef IMEM_LOADER_CKSUM_EN
        // Two-word image followed by a wrong checksum byte (correct one is 0x06).
        do_reset();
        exp_w.delete();
        exp_w.push_back(32'h00500013);
        exp_w.push_back(32'h00100093);
        build_stream(32'd2);
        check_val("model_cksum", 64'(stream_q[stream_q.size() - 1]), 64'h06);
        stream_q[stream_q.size() - 1] = 8'h7F;
        exp_ok = 1'b0;
        do_start();
        send_bytes(0);
        finish_load();
`endif

        // Reset after six data bytes: outputs clear and no further writes.
        do_reset();
        fill_words(3);
        build_stream(32'd3);
        while (stream_q.size() > 10) void'(stream_q.pop_back());
        do_start();
        send_bytes(0);
        #2;
        rst = 1'b0;
        #1;
        check_val("midload_reset_outs", 64'(outs_s), 64'd0);
        check_val("midload_writes_before", 64'(got_a.size()), 64'd1);
        if (got_d.size() > 0) check_val("midload_first_word", 64'(got_d[0]), 64'(exp_w[0]));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
            check_val("post_reset_outs", 64'(outs_s), 64'd0);
        end
        in_valid = 1'b0;
        check_val("post_reset_no_writes", 64'(got_a.size()), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
